ram_req_queue: RTL and testbench

//  Request buffer and sequencer directly upstream of the external-PSRAM controller state_machine.

---
 rtl/ram_req_pkg.sv | 26 ++
 rtl/ram_req_fifo.sv | 62 ++++++
 rtl/ram_req_queue.sv | 153 +++++++++++++++
 tb/tb_ram_req_queue.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_req_pkg.sv
// Shared types and defaults for the PSRAM request queue.
package ram_req_pkg;

  localparam int unsigned RAM_DATA_W = 17;
  localparam int unsigned RAM_ADDR_W = 26;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Queue entry layout at default widths, MSB first: {rw, addr, wdata}.
  typedef struct packed {
    logic                  rw;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } req_entry_t;

  function automatic int unsigned entry_width(input int unsigned addr_w, input int unsigned data_w);
    return 32'd1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/ram_req_fifo.sv
// Request FIFO: registered storage, head readable combinationally, count includes the in-flight entry.
module ram_req_fifo
#(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_fire_s;
  logic             pop_fire_s;

  // A full FIFO refuses a push even when the head leaves in the same cycle.
  assign push_fire_s = push && !full;
  assign pop_fire_s  = pop && !empty;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_fire_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_fire_s, pop_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ram_req_queue.sv
// CPU request queue and sequencer in front of the PSRAM controller.
// Optional busy watchdog: define RAM_REQ_TIMEOUT_EN.
module ram_req_queue
  import ram_req_pkg::*;
#(
  parameter int unsigned DATA_W      = RAM_DATA_W,
  parameter int unsigned ADDR_W      = RAM_ADDR_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    sm_mem,
  output logic                    sm_rw,
  output logic [ADDR_W-1:0]       sm_addr,
  output logic [DATA_W-1:0]       sm_wdata,
  input  logic                    sm_busy,
  input  logic [DATA_W-1:0]       sm_rdata,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic                    q_full,
  output logic                    q_empty
);

  localparam int unsigned ENTRY_W = entry_width(ADDR_W, DATA_W);

  state_t             state_r;
  logic               push_s;
  logic               pop_s;
  logic               timeout_hit_s;
  logic [ENTRY_W-1:0] head_s;

  assign req_ready = !q_full;
  assign push_s    = req_valid && req_ready;
  assign pop_s     = (state_r == ST_DONE);

  ram_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({req_rw, req_addr, req_wdata}),
    .head  (head_s),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef RAM_REQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            in_wait_s;

  assign in_wait_s     = (state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE);
  assign timeout_hit_s = in_wait_s && (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts cycles spent waiting on the controller, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_r <= '0;
    end else if (in_wait_s) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Sequencer: one request in flight, all controller and response outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      sm_mem    <= 1'b0;
      sm_rw     <= 1'b0;
      sm_addr   <= '0;
      sm_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!q_empty) begin
            state_r  <= ST_ISSUE;
            sm_mem   <= 1'b1;
            sm_rw    <= head_s[ENTRY_W-1];
            sm_addr  <= head_s[ENTRY_W-2 -: ADDR_W];
            sm_wdata <= head_s[DATA_W-1:0];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          sm_mem  <= 1'b0;
          state_r <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (timeout_hit_s) begin
            state_r   <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (sm_busy) begin
            state_r <= ST_WAIT_DONE;
          end else begin
            state_r <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_DONE: begin
          if (timeout_hit_s) begin
            state_r   <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (!sm_busy) begin
            state_r   <= ST_DONE;
            rsp_valid <= !sm_rw;
            if (!sm_rw) begin
              rsp_rdata <= sm_rdata;
            end
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          sm_mem    <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_queue.sv
// Directed scoreboard bench for ram_req_queue with a behavioural PSRAM controller model.
module tb_ram_req_queue;

  localparam int TIMEOUT_CYC = 255;

  typedef struct {
    logic        rw;
    logic [25:0] addr;
    logic [16:0] wdata;
  } iss_t;

  typedef struct {
    logic [16:0] data;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [25:0] req_addr;
  logic [16:0] req_wdata;
  logic        rsp_valid;
  logic [16:0] rsp_rdata;
  logic        rsp_err;
  logic        sm_mem;
  logic        sm_rw;
  logic [25:0] sm_addr;
  logic [16:0] sm_wdata;
  logic        sm_busy;
  logic [16:0] sm_rdata;
  logic [2:0]  q_count;
  logic        q_full;
  logic        q_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int n_mem    = 0;
  int n_rsp    = 0;
  int busy_len = 3;
  logic stuck_busy = 1'b0;
  logic [16:0] last_rsp_data = '0;

  iss_t iss_q[$];
  rsp_t exp_q[$];
  logic [16:0] ref_mem [logic [25:0]];
  logic [16:0] ctl_mem [logic [25:0]];

  ram_req_queue dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sm_mem    (sm_mem),
    .sm_rw     (sm_rw),
    .sm_addr   (sm_addr),
    .sm_wdata  (sm_wdata),
    .sm_busy   (sm_busy),
    .sm_rdata  (sm_rdata),
    .q_count   (q_count),
    .q_full    (q_full),
    .q_empty   (q_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [16:0] dflt_rd(input logic [25:0] a);
    return a[16:0] ^ 17'h0A5A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller model: busy one cycle after the strobe for busy_len cycles, data from its own store.
  always @(posedge clk) begin
    logic        m_mem;
    logic        m_rw;
    logic [25:0] m_addr;
    logic [16:0] m_wd;
    int          busy_left;
    m_mem  = sm_mem;
    m_rw   = sm_rw;
    m_addr = sm_addr;
    m_wd   = sm_wdata;
    #1;
    if (!rst) begin
      busy_left = 0;
      sm_busy   = 1'b0;
      sm_rdata  = '0;
    end else if (m_mem) begin
      if (m_rw) ctl_mem[m_addr] = m_wd;
      sm_rdata  = m_rw ? 17'h00000 : (ctl_mem.exists(m_addr) ? ctl_mem[m_addr] : dflt_rd(m_addr));
      busy_left = busy_len;
      sm_busy   = 1'b1;
    end else if (busy_left > 1) begin
      busy_left--;
    end else begin
      busy_left = 0;
      sm_busy   = stuck_busy;
    end
  end

  // Scoreboard monitor: issue order, response data and response timing.
  always @(negedge clk) begin
    logic busy_h1;
    logic busy_h2;
    logic rsp_prev;
    iss_t e;
    rsp_t r;
    if (rst) begin
      if (sm_mem) begin
        n_mem++;
        check("issue_pending", 64'(iss_q.size() != 0), 64'd1);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          check("issue_rw", 64'(sm_rw), 64'(e.rw));
          check("issue_addr", 64'(sm_addr), 64'(e.addr));
          if (e.rw) check("issue_wdata", 64'(sm_wdata), 64'(e.wdata));
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_data = rsp_rdata;
        check("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        check("rsp_one_cycle", 64'(rsp_prev), 64'd0);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
          check("rsp_err", 64'(rsp_err), 64'(r.err));
          if (!r.err) check("rsp_latency", 64'({busy_h2, busy_h1}), 64'd2);
        end
      end
    end
    busy_h2  = busy_h1;
    busy_h1  = sm_busy;
    rsp_prev = rsp_valid;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_req(input logic rw, input logic [25:0] a, input logic [16:0] d, input logic exp_err);
    iss_t e;
    rsp_t r;
    int   w;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    w = 0;
    while (!req_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", 64'(req_ready), 64'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    e.rw = rw; e.addr = a; e.wdata = d;
    iss_q.push_back(e);
    if (rw) begin
      ref_mem[a] = d;
    end else begin
      r.err  = exp_err;
      r.data = exp_err ? 17'h00000 : (ref_mem.exists(a) ? ref_mem[a] : dflt_rd(a));
      exp_q.push_back(r);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(q_empty && !sm_busy && exp_q.size() == 0 && iss_q.size() == 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(q_empty && exp_q.size() == 0 && iss_q.size() == 0), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int m0;
    int r0;
    int w;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_q_empty", 64'(q_empty), 64'd1);
    check("rst_q_count", 64'(q_count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_outputs", 64'({sm_mem, sm_rw, rsp_valid, rsp_err, q_full}), 64'd0);
    check("rst_sm_addr", 64'(sm_addr), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1. single write
    m0 = n_mem; r0 = n_rsp;
    push_req(1'b1, 26'h0000010, 17'h1ABCD, 1'b0);
    check("t1_count_after_push", 64'(q_count), 64'd1);
    wait_idle();
    check("t1_one_strobe", 64'(n_mem - m0), 64'd1);
    check("t1_no_rsp", 64'(n_rsp - r0), 64'd0);
    check("t1_q_count", 64'(q_count), 64'd0);

    // 2. read back
    r0 = n_rsp;
    push_req(1'b0, 26'h0000010, 17'h00000, 1'b0);
    wait_idle();
    check("t2_one_rsp", 64'(n_rsp - r0), 64'd1);
    check("t2_rdata", 64'(last_rsp_data), 64'h1ABCD);

    // 3. overfill by one
    busy_len = 5;
    m0 = n_mem; r0 = n_rsp;
    push_req(1'b1, 26'h0000100, 17'h00111, 1'b0);
    push_req(1'b0, 26'h0000100, 17'h00000, 1'b0);
    push_req(1'b1, 26'h0000200, 17'h00222, 1'b0);
    push_req(1'b0, 26'h0000200, 17'h00000, 1'b0);
    check("t3_full", 64'(q_full), 64'd1);
    check("t3_not_ready", 64'(req_ready), 64'd0);
    check("t3_count_full", 64'(q_count), 64'd4);
    push_req(1'b0, 26'h3FFFFFF, 17'h00000, 1'b0);
    check("t3_fifth_after_done", 64'(q_count), 64'd4);
    wait_idle();
    check("t3_strobes", 64'(n_mem - m0), 64'd5);
    check("t3_rsps", 64'(n_rsp - r0), 64'd3);

    // 6. push coinciding with the DONE pop
    busy_len = 4;
    push_req(1'b0, 26'h0000100, 17'h00000, 1'b0);
    push_req(1'b1, 26'h0000300, 17'h1F0F0, 1'b0);
    w = 0;
    while (!rsp_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("t6_in_done", 64'(rsp_valid), 64'd1);
    check("t6_count_before", 64'(q_count), 64'd2);
    push_req(1'b1, 26'h0000304, 17'h0F0F0, 1'b0);
    check("t6_count_after", 64'(q_count), 64'd2);
    wait_idle();

    // 4. reset during WAIT_DONE of a read
    busy_len = 6;
    push_req(1'b0, 26'h0000200, 17'h00000, 1'b0);
    push_req(1'b0, 26'h0000100, 17'h00000, 1'b0);
    w = 0;
    while (!sm_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("t4_busy_seen", 64'(sm_busy), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t4_async_outputs", 64'({sm_mem, sm_rw, rsp_valid, rsp_err, q_full}), 64'd0);
    check("t4_async_addr", 64'(sm_addr), 64'd0);
    check("t4_q_empty", 64'(q_empty), 64'd1);
    check("t4_q_count", 64'(q_count), 64'd0);
    check("t4_ready", 64'(req_ready), 64'd1);
    iss_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m0 = n_mem; r0 = n_rsp;
    repeat (20) @(negedge clk);
    check("t4_no_rsp_after", 64'(n_rsp - r0), 64'd0);
    check("t4_no_issue_after", 64'(n_mem - m0), 64'd0);

    // 5. controller stuck busy
    busy_len = 3;
    stuck_busy = 1'b1;
    r0 = n_rsp;
`ifdef RAM_REQ_TIMEOUT_EN
    push_req(1'b0, 26'h0000020, 17'h00000, 1'b1);
    w = 0;
    while (!sm_mem && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("t5_issued", 64'(sm_mem), 64'd1);
    w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 1000) begin
      w++;
      @(negedge clk);
    end
    check("t5_timeout_cycles", 64'(w), 64'(TIMEOUT_CYC));
    check("t5_err_rsp", 64'({rsp_valid, rsp_err}), 64'd3);
    stuck_busy = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle();
    check("t5_one_rsp", 64'(n_rsp - r0), 64'd1);
`else
    push_req(1'b0, 26'h0000020, 17'h00000, 1'b0);
    repeat (1000) @(negedge clk);
    check("t5_still_waiting", 64'(n_rsp - r0), 64'd0);
    check("t5_entry_held", 64'(q_count), 64'd1);
    check("t5_no_err", 64'(rsp_err), 64'd0);
    stuck_busy = 1'b0;
    wait_idle();
    check("t5_completes", 64'(n_rsp - r0), 64'd1);
    check("t5_rdata", 64'(last_rsp_data), 64'(dflt_rd(26'h0000020)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
